// File: rtl/rom_upload_reader_if.sv
// HPS upload bus and ROM RAM read-port bundle for rom_upload_reader.
// The slave modport is the reader; the master modport is the HPS/RAM side.
interface rom_upload_reader_if;
   logic        ioctl_upload;
   logic        ioctl_rd;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_din;
   logic        ioctl_wait;
   logic [15:0] rd_addr;
   logic [3:0]  rd_region;
   logic [95:0] q_bus;
   logic [15:0] upload_sum;

   modport master (
      output ioctl_upload,
      output ioctl_rd,
      output ioctl_addr,
      output q_bus,
      input  ioctl_din,
      input  ioctl_wait,
      input  rd_addr,
      input  rd_region,
      input  upload_sum
   );

   modport slave (
      input  ioctl_upload,
      input  ioctl_rd,
      input  ioctl_addr,
      input  q_bus,
      output ioctl_din,
      output ioctl_wait,
      output rd_addr,
      output rd_region,
      output upload_sum
   );
endinterface

// File: rtl/rom_upload_reader.sv
// Serves HPS upload byte reads from twelve ROM RAM regions (1-cycle RAM latency).
// Define UPLOAD_CHECKSUM_EN to enable the running 16-bit upload byte checksum.
module rom_upload_reader (
   input  logic               clk,
   input  logic               reset,
   rom_upload_reader_if.slave bus
);
   typedef enum logic [1:0] {IDLE, FETCH, CAPTURE} state_t;

   localparam int         NUM_REGIONS = 12;
   localparam logic [3:0] REGION_NONE = 4'd15;

   state_t      state_q;
   logic [7:0]  din_q;
   logic        wait_q;
   logic [15:0] rd_addr_q;
   logic [3:0]  rd_region_q;

   logic [3:0]  region_d;
   logic [15:0] local_d;
   logic [7:0]  q_bytes [NUM_REGIONS];
   logic [7:0]  sel_byte;
   logic        capture_en;

   generate
      for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_q_bytes
         assign q_bytes[gi] = bus.q_bus[gi*8 +: 8];
      end
   endgenerate

   // Program regions are 64 KB from 0x00000, graphics regions 32 KB from 0x40000.
   always_comb begin
      region_d = REGION_NONE;
      local_d  = bus.ioctl_addr[15:0];
      if (bus.ioctl_addr[24:19] == 6'd0) begin
         if (!bus.ioctl_addr[18]) begin
            region_d = {2'b00, bus.ioctl_addr[17:16]};
         end else begin
            region_d = 4'd4 + {1'b0, bus.ioctl_addr[17:15]};
            local_d  = {1'b0, bus.ioctl_addr[14:0]};
         end
      end
   end

   always_comb begin
      sel_byte = 8'hFF;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         if (rd_region_q == 4'(i)) begin
            sel_byte = q_bytes[i];
         end
      end
   end

   assign capture_en = (state_q == CAPTURE) && bus.ioctl_upload;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         din_q       <= 8'h00;
         wait_q      <= 1'b0;
         rd_addr_q   <= 16'h0000;
         rd_region_q <= REGION_NONE;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.ioctl_upload && bus.ioctl_rd) begin
                  rd_addr_q   <= local_d;
                  rd_region_q <= region_d;
                  wait_q      <= 1'b1;
                  state_q     <= FETCH;
               end
            end
            FETCH: begin
               if (!bus.ioctl_upload) begin
                  wait_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  state_q <= CAPTURE;
               end
            end
            CAPTURE: begin
               // An upload that ended during the fetch leaves the old byte in place.
               if (capture_en) begin
                  din_q <= sel_byte;
               end
               wait_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               wait_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.ioctl_din  = din_q;
   assign bus.ioctl_wait = wait_q;
   assign bus.rd_addr    = rd_addr_q;
   assign bus.rd_region  = rd_region_q;

`ifdef UPLOAD_CHECKSUM_EN
   logic        upload_q;
   logic [15:0] sum_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         upload_q <= 1'b0;
         sum_q    <= 16'h0000;
      end else begin
         upload_q <= bus.ioctl_upload;
         if (bus.ioctl_upload && !upload_q) begin
            sum_q <= 16'h0000;
         end else if (capture_en) begin
            sum_q <= sum_q + {8'h00, sel_byte};
         end
      end
   end

   assign bus.upload_sum = sum_q;
`else
   assign bus.upload_sum = 16'h0000;
`endif

endmodule

// File: tb/tb_rom_upload_reader.sv
// Directed bench for rom_upload_reader: transaction-level model plus literal checks.
// Checksum expectations follow UPLOAD_CHECKSUM_EN exactly as the design does.
module tb_rom_upload_reader;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_fails;
   int   cyc;

   rom_upload_reader_if bus ();

   rom_upload_reader dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Contents of every ROM RAM, as a function of region and local address.
   function automatic logic [7:0] ram_byte(input int region, input logic [15:0] a);
      int v;
      v = (int'(a[7:0]) + int'(a[15:8]) * 3 + region * 'h11) & 'hFF;
      return 8'(v ^ 'h4A);
   endfunction

   function automatic int region_of(input logic [24:0] a);
      int ai;
      ai = int'(a);
      if (ai >= 'h80000) return 15;
      if (ai < 'h40000) return ai / 'h10000;
      return 4 + (ai - 'h40000) / 'h8000;
   endfunction

   function automatic logic [15:0] local_of(input logic [24:0] a);
      int ai;
      ai = int'(a);
      if (ai < 'h40000) return 16'(ai % 'h10000);
      return 16'(ai % 'h8000);
   endfunction

   // Registered-read RAM bank feeding q_bus
   always @(posedge clk) begin
      for (int i = 0; i < 12; i++) begin
         bus.q_bus[i*8 +: 8] <= ram_byte(i, bus.rd_addr);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Transaction model: a read accepted at cycle t0 is in flight until t0+2.
   logic        m_pend;
   int          m_t0;
   logic [7:0]  m_din;
   logic [7:0]  m_byte;
   logic [3:0]  m_region;
   logic [15:0] m_addr;
   logic [15:0] m_sum;
   logic        m_prev;

   initial cyc = 0;

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      m_prev <= reset ? 1'b0 : bus.ioctl_upload;
      if (reset) begin
         m_pend   <= 1'b0;
         m_din    <= 8'h00;
         m_region <= 4'd15;
         m_addr   <= 16'h0000;
         m_sum    <= 16'h0000;
      end else begin
         if (m_pend) begin
            if (!bus.ioctl_upload) begin
               m_pend <= 1'b0;
            end else if (cyc == m_t0 + 2) begin
               m_pend <= 1'b0;
               m_din  <= m_byte;
`ifdef UPLOAD_CHECKSUM_EN
               m_sum  <= m_sum + 16'(m_byte);
`endif
            end
         end else if (bus.ioctl_upload && bus.ioctl_rd) begin
            m_pend   <= 1'b1;
            m_t0     <= cyc;
            m_region <= 4'(region_of(bus.ioctl_addr));
            m_addr   <= local_of(bus.ioctl_addr);
            m_byte   <= (region_of(bus.ioctl_addr) == 15) ? 8'hFF
                        : ram_byte(region_of(bus.ioctl_addr), local_of(bus.ioctl_addr));
         end
`ifdef UPLOAD_CHECKSUM_EN
         if (bus.ioctl_upload && !m_prev) m_sum <= 16'h0000;
`endif
      end
   end

   always @(negedge clk) begin
      if (cyc > 0) begin
         chk("model_wait", 32'(bus.ioctl_wait), 32'(m_pend));
         chk("model_din", 32'(bus.ioctl_din), 32'(m_din));
         chk("model_region", 32'(bus.rd_region), 32'(m_region));
         if (m_region != 4'd15) chk("model_rd_addr", 32'(bus.rd_addr), 32'(m_addr));
         chk("model_sum", 32'(bus.upload_sum), 32'(m_sum));
      end
   end

   // One strobe, then literal checks at T+1, T+2 and T+3; returns at T+3.
   task automatic read_check(input logic [24:0] a, input logic [3:0] exp_region,
                             input logic [15:0] exp_local, input bit chk_local,
                             input logic [7:0] exp_din, input bit chk_din);
      @(posedge clk); #1;
      bus.ioctl_rd   = 1'b1;
      bus.ioctl_addr = a;
      @(posedge clk); #1;
      bus.ioctl_rd = 1'b0;
      @(negedge clk);
      chk("t1_wait", 32'(bus.ioctl_wait), 32'd1);
      chk("t1_region", 32'(bus.rd_region), 32'(exp_region));
      if (chk_local) chk("t1_rd_addr", 32'(bus.rd_addr), 32'(exp_local));
      @(negedge clk);
      chk("t2_wait", 32'(bus.ioctl_wait), 32'd1);
      @(negedge clk);
      chk("t3_wait", 32'(bus.ioctl_wait), 32'd0);
      if (chk_din) chk("t3_din", 32'(bus.ioctl_din), 32'(exp_din));
      $display("read addr=0x%07h region=%0d rd_addr=0x%04h din=0x%02h sum=0x%04h",
               a, bus.rd_region, bus.rd_addr, bus.ioctl_din, bus.upload_sum);
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      reset            = 1'b1;
      bus.ioctl_upload = 1'b0;
      bus.ioctl_rd     = 1'b0;
      bus.ioctl_addr   = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_din", 32'(bus.ioctl_din), 32'h00);
      chk("rst_wait", 32'(bus.ioctl_wait), 32'd0);
      chk("rst_region", 32'(bus.rd_region), 32'd15);
      chk("rst_rd_addr", 32'(bus.rd_addr), 32'h0000);
      chk("rst_sum", 32'(bus.upload_sum), 32'h0000);
      @(posedge clk); #1;
      reset = 1'b0;

      // Strobe without an upload session is ignored
      bus.ioctl_rd   = 1'b1;
      bus.ioctl_addr = 25'h00010;
      @(posedge clk); #1;
      bus.ioctl_rd = 1'b0;
      @(negedge clk);
      chk("noupl_wait", 32'(bus.ioctl_wait), 32'd0);
      chk("noupl_region", 32'(bus.rd_region), 32'd15);

      @(posedge clk); #1;
      bus.ioctl_upload = 1'b1;

      read_check(25'h0080000, 4'd15, 16'h0000, 1'b0, 8'hFF, 1'b1);
      read_check(25'h0000048, 4'd0, 16'h0048, 1'b1, 8'h02, 1'b1);
      read_check(25'h000005A, 4'd0, 16'h005A, 1'b1, 8'h10, 1'b1);
`ifdef UPLOAD_CHECKSUM_EN
      chk("sum_three", 32'(bus.upload_sum), 32'h0111);
`else
      chk("sum_off", 32'(bus.upload_sum), 32'h0000);
`endif
      // Re-raise the upload session: sum clears one cycle after the rising edge
      @(posedge clk); #1;
      bus.ioctl_upload = 1'b0;
      @(posedge clk); #1;
      bus.ioctl_upload = 1'b1;
      @(negedge clk);
`ifdef UPLOAD_CHECKSUM_EN
      chk("sum_edge", 32'(bus.upload_sum), 32'h0111);
`endif
      @(negedge clk);
      chk("sum_cleared", 32'(bus.upload_sum), 32'h0000);

      read_check(25'h0000010, 4'd0, 16'h0010, 1'b1, 8'h5A, 1'b1);
      // 0x4C123 lies in the second 32 KB graphics window
      read_check(25'h004C123, 4'd5, 16'h4123, 1'b1, 8'h00, 1'b0);
      read_check(25'h0044123, 4'd4, 16'h4123, 1'b1, 8'h00, 1'b0);
      read_check(25'h007FFFF, 4'd11, 16'h7FFF, 1'b1, 8'h00, 1'b0);
      read_check(25'h003FFFF, 4'd3, 16'hFFFF, 1'b1, 8'h00, 1'b0);
      read_check(25'h1FFFFFF, 4'd15, 16'h0000, 1'b0, 8'hFF, 1'b1);

      // Strobes at T and T+1: only the first served; next strobe at T+3
      @(posedge clk); #1;
      bus.ioctl_rd   = 1'b1;
      bus.ioctl_addr = 25'h0020000;
      @(posedge clk); #1;
      bus.ioctl_addr = 25'h0000030;
      @(negedge clk);
      chk("b2b_t1_region", 32'(bus.rd_region), 32'd2);
      chk("b2b_t1_rd_addr", 32'(bus.rd_addr), 32'h0000);
      @(posedge clk); #1;
      bus.ioctl_rd = 1'b0;
      @(negedge clk);
      chk("b2b_t2_region", 32'(bus.rd_region), 32'd2);
      @(posedge clk); #1;
      bus.ioctl_rd   = 1'b1;
      bus.ioctl_addr = 25'h0000048;
      @(negedge clk);
      chk("b2b_t3_wait", 32'(bus.ioctl_wait), 32'd0);
      chk("b2b_t3_din", 32'(bus.ioctl_din), 32'h68);
      @(posedge clk); #1;
      bus.ioctl_rd = 1'b0;
      @(negedge clk);
      chk("b2b_t4_wait", 32'(bus.ioctl_wait), 32'd1);
      chk("b2b_t4_rd_addr", 32'(bus.rd_addr), 32'h0048);
      repeat (2) @(negedge clk);
      chk("b2b_t6_din", 32'(bus.ioctl_din), 32'h02);
      chk("b2b_t6_wait", 32'(bus.ioctl_wait), 32'd0);
      $display("back-to-back din=0x%02h", bus.ioctl_din);

      // Upload drops during the fetch: wait falls, din holds
      @(posedge clk); #1;
      bus.ioctl_rd   = 1'b1;
      bus.ioctl_addr = 25'h0000010;
      @(posedge clk); #1;
      bus.ioctl_rd     = 1'b0;
      bus.ioctl_upload = 1'b0;
      @(negedge clk);
      chk("abort_t1_wait", 32'(bus.ioctl_wait), 32'd1);
      @(negedge clk);
      chk("abort_t2_wait", 32'(bus.ioctl_wait), 32'd0);
      chk("abort_t2_din", 32'(bus.ioctl_din), 32'h02);
      repeat (2) @(negedge clk);
      chk("abort_t4_din", 32'(bus.ioctl_din), 32'h02);
      $display("abort din=0x%02h wait=%0b", bus.ioctl_din, bus.ioctl_wait);

      // Reset in the middle of a fetch
      @(posedge clk); #1;
      bus.ioctl_upload = 1'b1;
      @(posedge clk); #1;
      bus.ioctl_rd   = 1'b1;
      bus.ioctl_addr = 25'h0000048;
      @(posedge clk); #1;
      bus.ioctl_rd = 1'b0;
      reset        = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_din", 32'(bus.ioctl_din), 32'h00);
      chk("midrst_region", 32'(bus.rd_region), 32'd15);
      chk("midrst_wait", 32'(bus.ioctl_wait), 32'd0);
      repeat (3) @(negedge clk);
      chk("midrst_din_late", 32'(bus.ioctl_din), 32'h00);
      $display("reset mid-fetch din=0x%02h region=%0d", bus.ioctl_din, bus.rd_region);

      read_check(25'h0000010, 4'd0, 16'h0010, 1'b1, 8'h5A, 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
